// File: rtl/snn_noc_pkg.sv
// snn_noc_pkg: mesh packet field layout (dx[29:21], dy[20:12], payload[11:0]) and the edge-hop header check
package snn_noc_pkg;
  localparam int PKT_W = 30;
  localparam int PKT_DX_MSB = 29;
  localparam int PKT_DX_LSB = 21;
  localparam int PKT_DY_MSB = 20;
  localparam int PKT_DY_LSB = 12;
  localparam int DX_W = PKT_DX_MSB - PKT_DX_LSB + 1;
  function automatic logic dx_is_edge_hop(input logic [DX_W-1:0] dx);
    return (dx == DX_W'(1)) || (dx == {DX_W{1'b1}});
  endfunction
endpackage

// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo: first-word-fall-through circular FIFO; ports clk, reset, wr_en/wr_data in, rd_en in, rd_data head out, level occupancy out
module sync_fwft_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic wr, rd;
  always_comb begin
    wr = wr_en && (level_q != LW'(DEPTH));
    rd = rd_en && (level_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(rd);
    level_d = level_q + LW'(wr) - LW'(rd);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= wr_data;
  assign rd_data = mem_q[rd_ptr_q];
  assign level = level_q;
endmodule

// File: rtl/edge_spike_collector.sv
// edge_spike_collector: mesh-edge sink; pops din/empty_in via ren_out, checks dx, queues {dy,payload} for host out_valid/out_ready, keeps pkt/drop counters and sticky hdr_error
module edge_spike_collector
  import snn_noc_pkg::*;
#(
  parameter int PACKET_WIDTH = PKT_W,
  parameter int DX_MSB = PKT_DX_MSB,
  parameter int DX_LSB = PKT_DX_LSB,
  parameter int DY_MSB = PKT_DY_MSB,
  parameter int DY_LSB = PKT_DY_LSB,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH = 32,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int EW = DY_MSB + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_WIDTH-1:0] din,
  input  logic                    empty_in,
  output logic                    ren_out,
  input  logic                    enable,
  input  logic                    clear_stats,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DX_MSB-DY_MSB-1:0] out_dy,
  output logic [DY_LSB-1:0]       out_payload,
  output logic [LW-1:0]           fifo_level,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic                    hdr_error
);
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d, drop_count_q, drop_count_d;
  logic hdr_error_q, hdr_error_d;
  logic hdr_ok, accept, drop;
  logic [EW-1:0] head;
  always_comb begin
    ren_out = !reset && enable && !empty_in && (fifo_level != LW'(FIFO_DEPTH));
    hdr_ok = dx_is_edge_hop(din[DX_MSB:DX_LSB]);
    accept = ren_out && hdr_ok;
    drop = ren_out && !hdr_ok;
    pkt_count_d = clear_stats ? '0 : (accept && !(&pkt_count_q)) ? pkt_count_q + 1'b1 : pkt_count_q;
    drop_count_d = clear_stats ? '0 : (drop && !(&drop_count_q)) ? drop_count_q + 1'b1 : drop_count_q;
    hdr_error_d = !clear_stats && (hdr_error_q || drop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pkt_count_q <= '0;
      drop_count_q <= '0;
      hdr_error_q <= 1'b0;
    end else begin
      pkt_count_q <= pkt_count_d;
      drop_count_q <= drop_count_d;
      hdr_error_q <= hdr_error_d;
    end
  sync_fwft_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(accept),
    .wr_data(din[DY_MSB:0]),
    .rd_en(out_valid && out_ready),
    .rd_data(head),
    .level(fifo_level)
  );
  assign out_valid = fifo_level != '0;
  assign out_dy = head[EW-1:DY_LSB];
  assign out_payload = head[DY_LSB-1:0];
  assign pkt_count = pkt_count_q;
  assign drop_count = drop_count_q;
  assign hdr_error = hdr_error_q;
endmodule

// File: tb/tb_edge_spike_collector.sv
// tb_edge_spike_collector: directed bench with packet source model and payload scoreboard
module tb_edge_spike_collector;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, clear_stats = 1'b0, out_ready = 1'b0, empty_in = 1'b1;
  logic [29:0] din = '0;
  logic ren_out, out_valid, hdr_error;
  logic [8:0] out_dy;
  logic [11:0] out_payload;
  logic [4:0] fifo_level;
  logic [31:0] pkt_count, drop_count;
  logic ren4, valid4, hdr4;
  logic [8:0] dy4;
  logic [11:0] pl4;
  logic [4:0] lvl4;
  logic [3:0] pkt4, drop4;
  int tests = 0, fails = 0, pops = 0, reads = 0, lvl_bad = 0;
  logic [29:0] src [$];
  logic [20:0] exp_q [$];
  edge_spike_collector dut (
    .clk(clk), .reset(reset), .din(din), .empty_in(empty_in), .ren_out(ren_out),
    .enable(enable), .clear_stats(clear_stats), .out_valid(out_valid), .out_ready(out_ready),
    .out_dy(out_dy), .out_payload(out_payload), .fifo_level(fifo_level),
    .pkt_count(pkt_count), .drop_count(drop_count), .hdr_error(hdr_error)
  );
  edge_spike_collector #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .din(din), .empty_in(empty_in), .ren_out(ren4),
    .enable(enable), .clear_stats(clear_stats), .out_valid(valid4), .out_ready(out_ready),
    .out_dy(dy4), .out_payload(pl4), .fifo_level(lvl4),
    .pkt_count(pkt4), .drop_count(drop4), .hdr_error(hdr4)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [29:0] mk(input logic [8:0] dx, input logic [8:0] dy, input logic [11:0] pl);
    return {dx, dy, pl};
  endfunction
  function automatic bit hdr_ok(input logic [8:0] dx);
    return dx == 9'd1 || dx == 9'h1FF;
  endfunction
  task automatic drive();
    empty_in = src.size() == 0;
    din = empty_in ? '0 : src[0];
  endtask
  task automatic tick();
    logic r, rd;
    logic [20:0] hd;
    logic [29:0] dn;
    #1;
    r = ren_out;
    rd = out_valid && out_ready;
    hd = {out_dy, out_payload};
    dn = din;
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      pops++;
      void'(src.pop_front());
      if (hdr_ok(dn[29:21])) exp_q.push_back(dn[20:0]);
    end
    if (rd) begin
      reads++;
      if (exp_q.size() == 0) chk("rd_extra", 1, 0);
      else chk("rd_order", hd, exp_q.pop_front());
    end
    drive();
    #1;
  endtask
  task automatic drain(input int max);
    out_ready = 1'b1;
    for (int i = 0; i < max && (exp_q.size() != 0 || src.size() != 0); i++) tick();
    chk("drain_done", exp_q.size() + src.size(), 0);
  endtask
  initial begin
    enable = 1'b1;
    empty_in = 1'b0;
    din = mk(9'd1, 9'd2, 12'h123);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ren", ren_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_hdr", hdr_error, 0);
    drive();
    @(negedge clk);
    reset = 1'b0;
    #1;
    src.push_back(mk(9'd1, 9'h1FD, 12'h5A7));
    drive();
    #1;
    chk("single_ren", ren_out, 1);
    tick();
    chk("single_ren_off", ren_out, 0);
    chk("single_valid", out_valid, 1);
    chk("single_dy", out_dy, 9'h1FD);
    chk("single_pl", out_payload, 12'h5A7);
    chk("single_pkt", pkt_count, 1);
    chk("single_pops", pops, 1);
    drain(10);
    pops = 0;
    reads = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) src.push_back(mk(i[0] ? 9'h1FF : 9'd1, 9'(i), 12'h100 + 12'(i)));
    drive();
    repeat (25) tick();
    chk("fill_pops", pops, 16);
    chk("fill_level", fifo_level, 16);
    chk("fill_ren", ren_out, 0);
    drain(60);
    chk("fill_reads", reads, 20);
    chk("fill_pops_all", pops, 20);
    chk("fill_empty", fifo_level, 0);
    pops = 0;
    reads = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) src.push_back(mk(9'd1, 9'd5, 12'h200 + 12'(i)));
    drive();
    repeat (5) tick();
    chk("cc_prefill", fifo_level, 5);
    for (int i = 5; i < 105; i++) src.push_back(mk(9'h1FF, 9'(i), 12'h200 + 12'(i)));
    out_ready = 1'b1;
    drive();
    repeat (100) begin
      tick();
      if (fifo_level != 5'd5) lvl_bad++;
    end
    chk("cc_level_hold", lvl_bad, 0);
    chk("cc_reads", reads, 100);
    drain(20);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clr_pkt", pkt_count, 0);
    pops = 0;
    reads = 0;
    src.push_back(mk(9'd3, 9'd1, 12'hBAD));
    src.push_back(mk(9'd0, 9'd1, 12'hBAD));
    src.push_back(mk(9'd1, 9'd7, 12'hABC));
    drive();
    repeat (5) tick();
    chk("bad_pops", pops, 3);
    chk("bad_drop", drop_count, 2);
    chk("bad_hdr", hdr_error, 1);
    chk("bad_pkt", pkt_count, 1);
    chk("bad_reads", reads, 1);
    clear_stats = 1'b1;
    out_ready = 1'b0;
    src.push_back(mk(9'd1, 9'd9, 12'h777));
    drive();
    tick();
    clear_stats = 1'b0;
    chk("clracc_pkt", pkt_count, 0);
    chk("clracc_drop", drop_count, 0);
    chk("clracc_hdr", hdr_error, 0);
    chk("clracc_level", fifo_level, 1);
    drain(10);
    for (int i = 0; i < 20; i++) src.push_back(mk(9'd1, 9'd4, 12'h300 + 12'(i)));
    drive();
    drain(60);
    chk("sat_pkt32", pkt_count, 20);
    chk("sat_pkt4", pkt4, 15);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) src.push_back(mk(9'd1, 9'd6, 12'h400 + 12'(i)));
    drive();
    repeat (7) tick();
    chk("mid_level", fifo_level, 7);
    chk("mid_ren", ren_out, 1);
    reset = 1'b1;
    #1;
    chk("mid_ren_rst", ren_out, 0);
    tick();
    reset = 1'b0;
    src.delete();
    exp_q.delete();
    drive();
    #1;
    chk("post_level", fifo_level, 0);
    chk("post_valid", out_valid, 0);
    chk("post_pkt", pkt_count, 0);
    chk("post_drop", drop_count, 0);
    chk("post_hdr", hdr_error, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
